// File: rtl/multicycle_control_unit_if.sv
// Control bundle between the multicycle RV32I controller and its datapath.
// master: controller side. It receives the instruction fields and ALU flags
//         and drives the enables, selects, ALUControl, illegal, instr_done
//         and retired.
// slave:  datapath side, with the directions reversed.
interface multicycle_control_unit_if #(
    parameter int ALU_CTRL_W = 3,
    parameter int CNT_W      = 32
);
    logic [6:0]            op;
    logic [2:0]            funct3;
    logic                  funct7b5;
    logic                  Zero;
    logic                  Lt;
    logic                  Ltu;
    logic                  PCWrite;
    logic                  AdrSrc;
    logic                  MemWrite;
    logic                  IRWrite;
    logic                  RegWrite;
    logic [1:0]            ResultSrc;
    logic [1:0]            ALUSrcA;
    logic [1:0]            ALUSrcB;
    logic [1:0]            ImmSrc;
    logic [ALU_CTRL_W-1:0] ALUControl;
    logic                  illegal;
    logic                  instr_done;
    logic [CNT_W-1:0]      retired;

    modport master (
        input  op, funct3, funct7b5, Zero, Lt, Ltu,
        output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal, instr_done, retired
    );

    modport slave (
        output op, funct3, funct7b5, Zero, Lt, Ltu,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal, instr_done, retired
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Moore-FSM controller for the multicycle RV32I datapath.
// Each instruction is sequenced through fetch, decode, execute, memory and
// writeback in 3 to 5 cycles. Unknown opcodes enter a sticky trap state that
// only reset can leave. Retired instructions are counted.
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - multicycle_control_unit_if.master. Inputs are op, funct3,
//           funct7b5, Zero, Lt and Ltu. Outputs are the datapath enables and
//           selects, ALUControl, illegal, instr_done and retired.
module multicycle_control_unit #(
    parameter int ALU_CTRL_W = 3,
    parameter bit BRANCH_EXT = 1'b1,
    parameter int CNT_W      = 32
) (
    input  logic clk,
    input  logic rst_n,
    multicycle_control_unit_if.master bus
);
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef struct packed {
        logic       pcw;
        logic       adrsrc;
        logic       memw;
        logic       irw;
        logic       regw;
        logic [1:0] ressrc;
        logic [1:0] srca;
        logic [1:0] srcb;
        logic [1:0] aluop;
        logic       br;
        logic       ill;
        logic       done;
    } ctl_t;

    function automatic ctl_t ctl_of(input state_t s);
        ctl_t c;
        c = '0;
        case (s)
            S_FETCH:    begin c.irw = 1'b1; c.srcb = 2'b10; c.ressrc = 2'b10; c.pcw = 1'b1; end
            S_DECODE:   begin c.srca = 2'b01; c.srcb = 2'b01; end
            S_MEMADR:   begin c.srca = 2'b10; c.srcb = 2'b01; end
            S_MEMREAD:  c.adrsrc = 1'b1;
            S_MEMWB:    begin c.ressrc = 2'b01; c.regw = 1'b1; c.done = 1'b1; end
            S_MEMWRITE: begin c.adrsrc = 1'b1; c.memw = 1'b1; c.done = 1'b1; end
            S_EXECR:    begin c.srca = 2'b10; c.aluop = 2'b10; end
            S_EXECI:    begin c.srca = 2'b10; c.srcb = 2'b01; c.aluop = 2'b10; end
            S_ALUWB:    begin c.regw = 1'b1; c.done = 1'b1; end
            S_BRANCH:   begin c.srca = 2'b10; c.aluop = 2'b01; c.br = 1'b1; c.done = 1'b1; end
            S_JAL:      begin c.srca = 2'b01; c.srcb = 2'b10; c.pcw = 1'b1; end
            S_TRAP:     c.ill = 1'b1;
            default:    ;
        endcase
        return c;
    endfunction

    state_t           state_q;
    state_t           state_d;
    ctl_t             ctl_q;
    logic [CNT_W-1:0] retired_q;
    logic             taken;
    logic [2:0]       alu3;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_BR:        state_d = S_BRANCH;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = S_TRAP;
                endcase
            end
            S_MEMADR:  state_d = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD: state_d = S_MEMWB;
            S_MEMWB, S_MEMWRITE, S_ALUWB, S_BRANCH: state_d = S_FETCH;
            S_EXECR, S_EXECI, S_JAL: state_d = S_ALUWB;
            S_TRAP:    state_d = S_TRAP;
            default:   state_d = S_FETCH;
        endcase
    end

    // The output register is loaded from the next state, so it always holds
    // the outputs of the current state. Its reset value is FETCH's, enables
    // included, which is why the enables are masked with rst_n below.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            ctl_q     <= ctl_of(S_FETCH);
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            ctl_q   <= ctl_of(state_d);
            if (ctl_q.done) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    // The ALU flags belong to the compare made in the BRANCH cycle itself,
    // so the branch decision cannot be registered.
    always_comb begin
        taken = 1'b0;
        case (bus.funct3)
            3'b000:  taken = bus.Zero;
            3'b001:  taken = !bus.Zero;
            3'b100:  taken = bus.Lt;
            3'b101:  taken = !bus.Lt;
            3'b110:  taken = bus.Ltu;
            3'b111:  taken = !bus.Ltu;
            default: taken = 1'b0;
        endcase
        if (!BRANCH_EXT && (bus.funct3 != 3'b000)) begin
            taken = 1'b0;
        end
    end

    always_comb begin
        alu3 = 3'b000;
        case (ctl_q.aluop)
            2'b01: alu3 = 3'b001;
            2'b10: begin
                case (bus.funct3)
                    3'b000:  alu3 = (bus.funct7b5 & bus.op[5]) ? 3'b001 : 3'b000;
                    3'b010:  alu3 = 3'b101;
                    3'b100:  alu3 = 3'b100;
                    3'b110:  alu3 = 3'b011;
                    3'b111:  alu3 = 3'b010;
                    default: alu3 = 3'b000;
                endcase
            end
            default: alu3 = 3'b000;
        endcase
    end

    always_comb begin
        case (bus.op)
            OP_SW:   bus.ImmSrc = 2'b01;
            OP_BR:   bus.ImmSrc = 2'b10;
            OP_JAL:  bus.ImmSrc = 2'b11;
            default: bus.ImmSrc = 2'b00;
        endcase
    end

    assign bus.PCWrite    = rst_n & (ctl_q.pcw | (ctl_q.br & taken));
    assign bus.IRWrite    = rst_n & ctl_q.irw;
    assign bus.MemWrite   = rst_n & ctl_q.memw;
    assign bus.RegWrite   = rst_n & ctl_q.regw;
    assign bus.AdrSrc     = ctl_q.adrsrc;
    assign bus.ResultSrc  = ctl_q.ressrc;
    assign bus.ALUSrcA    = ctl_q.srca;
    assign bus.ALUSrcB    = ctl_q.srcb;
    assign bus.ALUControl = ALU_CTRL_W'(alu3);
    assign bus.illegal    = ctl_q.ill;
    assign bus.instr_done = ctl_q.done;
    assign bus.retired    = retired_q;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit. Two instances share the same stimulus:
// dut1 uses the defaults, and dut2 uses BRANCH_EXT=0 with a 4-bit counter.
// The reference model is indexed by instruction class and by the cycle
// number within the instruction.
module tb_multicycle_control_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [6:0] op = 7'b0000011;
    logic [2:0] f3 = 3'b000;
    logic       f7 = 1'b0;
    logic       zero = 1'b0, lt = 1'b0, ltu = 1'b0;

    multicycle_control_unit_if #(.ALU_CTRL_W(3), .CNT_W(32)) bus1();
    multicycle_control_unit_if #(.ALU_CTRL_W(3), .CNT_W(4))  bus2();

    assign bus1.op = op;   assign bus2.op = op;
    assign bus1.funct3 = f3; assign bus2.funct3 = f3;
    assign bus1.funct7b5 = f7; assign bus2.funct7b5 = f7;
    assign bus1.Zero = zero; assign bus2.Zero = zero;
    assign bus1.Lt = lt;   assign bus2.Lt = lt;
    assign bus1.Ltu = ltu; assign bus2.Ltu = ltu;

    multicycle_control_unit #(.ALU_CTRL_W(3), .BRANCH_EXT(1'b1), .CNT_W(32))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    multicycle_control_unit #(.ALU_CTRL_W(3), .BRANCH_EXT(1'b0), .CNT_W(4))
        dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    localparam int C_LOAD = 0, C_STORE = 1, C_R = 2, C_I = 3, C_BR = 4, C_JAL = 5, C_ILL = 6;

    int checks = 0;
    int errors = 0;
    int cls = 0;
    int cyc = 0;
    int unsigned exp_ret = 0;

    logic       e_pcw1, e_pcw2, e_adr, e_memw, e_irw, e_regw, e_ill, e_done;
    logic [1:0] e_res, e_sa, e_sb;
    logic [2:0] e_alu;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int cls_of(input logic [6:0] o);
        case (o)
            7'b0000011: return C_LOAD;
            7'b0100011: return C_STORE;
            7'b0110011: return C_R;
            7'b0010011: return C_I;
            7'b1100011: return C_BR;
            7'b1101111: return C_JAL;
            default:    return C_ILL;
        endcase
    endfunction

    function automatic int len_of(input int c);
        if (c == C_LOAD) return 5;
        if (c == C_BR) return 3;
        if (c == C_ILL) return 100000;
        return 4;
    endfunction

    function automatic logic [1:0] imm_of(input logic [6:0] o);
        if (o == 7'b0100011) return 2'b01;
        if (o == 7'b1100011) return 2'b10;
        if (o == 7'b1101111) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [2:0] alu_fn(input logic [6:0] o, input logic [2:0] fn, input logic b5);
        case (fn)
            3'b000:  return (b5 && o[5]) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b100:  return 3'b100;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic taken_fn(input logic [2:0] fn, input logic z, input logic l,
                                      input logic lu, input logic ext);
        if (!ext) return (fn == 3'b000) && z;
        case (fn)
            3'b000:  return z;
            3'b001:  return !z;
            3'b100:  return l;
            3'b101:  return !l;
            3'b110:  return lu;
            3'b111:  return !lu;
            default: return 1'b0;
        endcase
    endfunction

    // Outputs expected in cycle number cyc of an instruction of class cls.
    task automatic predict();
        {e_pcw1, e_pcw2, e_adr, e_memw, e_irw, e_regw, e_ill, e_done} = '0;
        e_res = 2'b00; e_sa = 2'b00; e_sb = 2'b00; e_alu = 3'b000;
        if (cyc == 0) begin
            e_pcw1 = 1'b1; e_pcw2 = 1'b1; e_irw = 1'b1; e_res = 2'b10; e_sb = 2'b10;
        end else if (cyc == 1) begin
            e_sa = 2'b01; e_sb = 2'b01;
        end else begin
            case (cls)
                C_LOAD: begin
                    if (cyc == 2) begin e_sa = 2'b10; e_sb = 2'b01; end
                    else if (cyc == 3) e_adr = 1'b1;
                    else begin e_res = 2'b01; e_regw = 1'b1; e_done = 1'b1; end
                end
                C_STORE: begin
                    if (cyc == 2) begin e_sa = 2'b10; e_sb = 2'b01; end
                    else begin e_adr = 1'b1; e_memw = 1'b1; e_done = 1'b1; end
                end
                C_R, C_I: begin
                    if (cyc == 2) begin
                        e_sa = 2'b10; e_sb = (cls == C_I) ? 2'b01 : 2'b00; e_alu = alu_fn(op, f3, f7);
                    end else begin e_regw = 1'b1; e_done = 1'b1; end
                end
                C_BR: begin
                    e_sa = 2'b10; e_alu = 3'b001; e_done = 1'b1;
                    e_pcw1 = taken_fn(f3, zero, lt, ltu, 1'b1);
                    e_pcw2 = taken_fn(f3, zero, lt, ltu, 1'b0);
                end
                C_JAL: begin
                    if (cyc == 2) begin e_sa = 2'b01; e_sb = 2'b10; e_pcw1 = 1'b1; e_pcw2 = 1'b1; end
                    else begin e_regw = 1'b1; e_done = 1'b1; end
                end
                default: e_ill = 1'b1;
            endcase
        end
    endtask

    task automatic compare_all();
        chk("PCWrite", 32'(bus1.PCWrite), 32'(e_pcw1));
        chk("PCWrite_b0", 32'(bus2.PCWrite), 32'(e_pcw2));
        chk("AdrSrc", 32'(bus1.AdrSrc), 32'(e_adr));
        chk("MemWrite", 32'(bus1.MemWrite), 32'(e_memw));
        chk("IRWrite", 32'(bus1.IRWrite), 32'(e_irw));
        chk("RegWrite", 32'(bus1.RegWrite), 32'(e_regw));
        chk("RegWrite_b0", 32'(bus2.RegWrite), 32'(e_regw));
        chk("ResultSrc", 32'(bus1.ResultSrc), 32'(e_res));
        chk("ALUSrcA", 32'(bus1.ALUSrcA), 32'(e_sa));
        chk("ALUSrcB", 32'(bus1.ALUSrcB), 32'(e_sb));
        chk("ImmSrc", 32'(bus1.ImmSrc), 32'(imm_of(op)));
        chk("ALUControl", 32'(bus1.ALUControl), 32'(e_alu));
        chk("illegal", 32'(bus1.illegal), 32'(e_ill));
        chk("instr_done", 32'(bus1.instr_done), 32'(e_done));
        chk("retired", bus1.retired, exp_ret);
        chk("retired_w4", 32'(bus2.retired), exp_ret % 16);
    endtask

    // Called away from a clock edge; returns at 1 time unit after a rising
    // edge with rst_n high and the model back at cycle 0.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        exp_ret = 0;
        cyc = 0;
        for (int k = 0; k < 2; k++) begin
            chk("rst_PCWrite", 32'(bus1.PCWrite | bus2.PCWrite), 32'd0);
            chk("rst_IRWrite", 32'(bus1.IRWrite), 32'd0);
            chk("rst_MemWrite", 32'(bus1.MemWrite), 32'd0);
            chk("rst_RegWrite", 32'(bus1.RegWrite | bus2.RegWrite), 32'd0);
            chk("rst_instr_done", 32'(bus1.instr_done), 32'd0);
            chk("rst_illegal", 32'(bus1.illegal), 32'd0);
            chk("rst_retired", bus1.retired, 32'd0);
            chk("rst_retired_w4", 32'(bus2.retired), 32'd0);
            chk("rst_AdrSrc", 32'(bus1.AdrSrc), 32'd0);
            chk("rst_ResultSrc", 32'(bus1.ResultSrc), 32'd2);
            chk("rst_ALUSrcA", 32'(bus1.ALUSrcA), 32'd0);
            chk("rst_ALUSrcB", 32'(bus1.ALUSrcB), 32'd2);
            chk("rst_ALUControl", 32'(bus1.ALUControl), 32'd0);
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
    endtask

    // Runs one instruction starting in its fetch cycle, 1 time unit after a
    // rising edge. zfix < 0 randomises Zero. Lt and Ltu are always random.
    task automatic do_instr(input logic [6:0] o, input logic [2:0] fn3, input logic b5,
                            input int zfix, input int maxcyc, input int abort_at,
                            output int ncyc, output logic [2:0] alu_seen,
                            output logic pcw1_seen, output logic pcw2_seen);
        op = o; f3 = fn3; f7 = b5;
        cls = cls_of(o);
        cyc = 0;
        ncyc = 0;
        alu_seen = 3'b000; pcw1_seen = 1'b0; pcw2_seen = 1'b0;
        do begin
            zero = (zfix < 0) ? 1'($urandom_range(0, 1)) : zfix[0];
            lt   = 1'($urandom_range(0, 1));
            ltu  = 1'($urandom_range(0, 1));
            #1;
            predict();
            compare_all();
            if (cyc == 2) begin
                alu_seen = bus1.ALUControl; pcw1_seen = bus1.PCWrite; pcw2_seen = bus2.PCWrite;
            end
            if (cyc == abort_at) begin
                do_reset();
                ncyc = -1;
                return;
            end
            if (e_done) exp_ret++;
            cyc = (cyc + 1 == len_of(cls)) ? 0 : cyc + 1;
            ncyc++;
            @(posedge clk);
            #1;
        end while (cyc != 0 && ncyc < maxcyc);
    endtask

    logic [6:0] ops [6] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111};

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin : main
        int n;
        logic [2:0] a;
        logic p1, p2;
        #2;
        do_reset();

        do_instr(7'b0000011, 3'b010, 1'b0, -1, 10, -1, n, a, p1, p2);
        chk("lw_cycles", 32'(n), 32'd5);
        chk("lw_retired", bus1.retired, 32'd1);

        do_instr(7'b0100011, 3'b010, 1'b0, -1, 10, -1, n, a, p1, p2);
        chk("sw_cycles", 32'(n), 32'd4);

        do_instr(7'b0110011, 3'b000, 1'b1, -1, 10, -1, n, a, p1, p2);
        chk("sub_alu", 32'(a), 32'd1);
        do_instr(7'b0110011, 3'b000, 1'b0, -1, 10, -1, n, a, p1, p2);
        chk("add_alu", 32'(a), 32'd0);
        do_instr(7'b0010011, 3'b000, 1'b1, -1, 10, -1, n, a, p1, p2);
        chk("addi_alu", 32'(a), 32'd0);

        do_instr(7'b1100011, 3'b001, 1'b0, 0, 10, -1, n, a, p1, p2);
        chk("bne_taken", 32'(p1), 32'd1);
        chk("bne_b0_not_taken", 32'(p2), 32'd0);
        chk("bne_cycles", 32'(n), 32'd3);
        do_instr(7'b1100011, 3'b001, 1'b0, 1, 10, -1, n, a, p1, p2);
        chk("bne_not_taken", 32'(p1), 32'd0);
        do_instr(7'b1100011, 3'b000, 1'b0, 1, 10, -1, n, a, p1, p2);
        chk("beq_b0_taken", 32'(p2), 32'd1);

        do_instr(7'b1111111, 3'b000, 1'b0, -1, 22, -1, n, a, p1, p2);
        chk("trap_cycles", 32'(n), 32'd22);
        chk("trap_illegal", 32'(bus1.illegal), 32'd1);
        do_reset();
        #1;
        chk("post_trap_illegal", 32'(bus1.illegal), 32'd0);
        chk("post_trap_fetch", 32'(bus1.IRWrite), 32'd1);

        for (int i = 0; i < 17; i++) begin
            do_instr(ops[$urandom_range(0, 5)], 3'($urandom), 1'($urandom), -1, 10, -1, n, a, p1, p2);
        end
        chk("wrap17_w4", 32'(bus2.retired), 32'd1);
        chk("wrap17_w32", bus1.retired, 32'd17);

        do_instr(7'b0000011, 3'b010, 1'b0, -1, 10, 3, n, a, p1, p2);

        for (int i = 0; i < 200; i++) begin
            int r;
            logic [6:0] o;
            r = int'($urandom_range(0, 19));
            if (r == 0) begin
                o = 7'($urandom);
                if (cls_of(o) != C_ILL) o = 7'b0000000;
                do_instr(o, 3'($urandom), 1'($urandom), -1, 4 + int'($urandom_range(0, 3)), -1, n, a, p1, p2);
                do_reset();
            end else begin
                o = ops[$urandom_range(0, 5)];
                do_instr(o, 3'($urandom), 1'($urandom), -1, 10,
                         (r == 1) ? int'($urandom_range(0, 2)) : -1, n, a, p1, p2);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
